// File: rtl/dbus_io.sv
// Data-bus target for the 16-bit CPU: data RAM, GPO register, TX FIFO and cycle counter.
// Define DBUS_IO_CYCLE_COUNTER_EN to implement the cycle counter at 0xFF03.
module dbus_io #(
  parameter int FIFO_DEPTH = 8,
  parameter int RAM_WORDS  = 256
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  logic [15:0] DD,
  input  logic        RW,
  output logic [15:0] GPO,
  output logic [15:0] TXD,
  output logic        TXV,
  input  logic        TXR
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [15:0] A_GPO = 16'hFF00;
  localparam logic [15:0] A_TX  = 16'hFF01;
  localparam logic [15:0] A_ST  = 16'hFF02;
  localparam logic [15:0] A_CNT = 16'hFF03;
  localparam logic [16:0] RAM_LIM = 17'(RAM_WORDS);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] fifo [FIFO_DEPTH];

  logic          prev_rw;
  logic [15:0]   prev_da, prev_dd;
  logic          we, ram_sel;
  logic [15:0]   rdata;
  logic [15:0]   gpo_q;
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count, count_nx;
  logic          txv_q, ovf;
  logic          push_req, push, pop, full, empty;
  logic [15:0]   cnt_val;

  // A store is committed only on the first edge of an episode; held cycles repeat nothing.
  always_comb begin
    ram_sel = ({1'b0, DA} < RAM_LIM);
    we      = !RW && (prev_rw || (DA != prev_da) || (DD != prev_dd));
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      prev_rw <= 1'b1;
      prev_da <= '0;
      prev_dd <= '0;
    end else begin
      prev_rw <= RW;
      prev_da <= DA;
      prev_dd <= DD;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST && we && ram_sel)
      ram[DA[AW-1:0]] <= DD;
  end

  always_ff @(posedge CK) begin
    if (RST)
      gpo_q <= '0;
    else if (we && DA == A_GPO)
      gpo_q <= DD;
  end

  always_comb begin
    empty    = (count == '0);
    full     = (count == DEPTH);
    pop      = txv_q && TXR;
    push_req = we && (DA == A_TX);
    push     = push_req && (!full || pop);
    count_nx = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      txv_q <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_nx;
      txv_q <= (count_nx != '0);
      if (we && DA == A_ST)
        ovf <= 1'b0;
      else if (push_req && full && !pop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST && push)
      fifo[wptr] <= DD;
  end

`ifdef DBUS_IO_CYCLE_COUNTER_EN
  logic [15:0] cnt_q;
  always_ff @(posedge CK) begin
    if (RST)
      cnt_q <= '0;
    else if (we && DA == A_CNT)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 16'd1;
  end
  assign cnt_val = cnt_q;
`else
  assign cnt_val = '0;
`endif

  always_comb begin
    rdata = '0;
    if (ram_sel)
      rdata = ram[DA[AW-1:0]];
    else begin
      case (DA)
        A_GPO:   rdata = gpo_q;
        A_TX:    rdata = 16'(count);
        A_ST:    rdata = {13'd0, ovf, empty, full};
        A_CNT:   rdata = cnt_val;
        default: rdata = '0;
      endcase
    end
  end

  assign DD  = RW ? rdata : 16'bz;
  assign GPO = gpo_q;
  assign TXV = txv_q;
  assign TXD = txv_q ? fifo[rptr] : '0;

endmodule

// File: tb/tb_dbus_io.sv
// Directed self-checking bench for dbus_io: RAM, GPO, TX FIFO handshake/overflow, coalescing, reset.
module tb_dbus_io;

  logic        ck = 1'b0;
  logic        rst, rw, txr;
  logic [15:0] da, dd_drv;
  wire  [15:0] dd;
  logic [15:0] gpo, txd;
  logic        txv;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  assign dd = rw ? 16'bz : dd_drv;

  dbus_io #(.FIFO_DEPTH(8), .RAM_WORDS(256)) dut (
    .CK(ck), .RST(rst), .DA(da), .DD(dd), .RW(rw),
    .GPO(gpo), .TXD(txd), .TXV(txv), .TXR(txr)
  );

  always #5 ck = ~ck;

  // Called just after a negedge: one committing edge, then one idle edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    rw = 1'b0; da = a; dd_drv = d;
    @(negedge ck);
    rw = 1'b1;
    @(negedge ck);
  endtask

  // Zero-edge combinational load.
  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    rw = 1'b1; da = a;
    #1;
    d = dd;
  endtask

  task automatic test_reset;
    logic [15:0] r;
    rst = 1'b1; rw = 1'b1; da = '0; dd_drv = '0; txr = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b0;
    vectors++; if (gpo !== 16'h0000) begin errors++; $display("FAIL reset_gpo got %h exp %h", gpo, 16'h0000); end
    vectors++; if (txv !== 1'b0) begin errors++; $display("FAIL reset_txv got %b exp %b", txv, 1'b0); end
    vectors++; if (txd !== 16'h0000) begin errors++; $display("FAIL reset_txd got %h exp %h", txd, 16'h0000); end
    peek(16'hFF02, r);
    vectors++; if (r !== 16'h0002) begin errors++; $display("FAIL reset_status got %h exp %h", r, 16'h0002); end
    peek(16'hFF01, r);
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp %h", r, 16'h0000); end
    peek(16'hFF03, r);
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL reset_cycles got %h exp %h", r, 16'h0000); end
    @(negedge ck);
  endtask

  task automatic test_ram;
    logic [15:0] r;
    bus_write(16'h0010, 16'h1234);
    peek(16'h0010, r);
    vectors++; if (r !== 16'h1234) begin errors++; $display("FAIL ram_rd got %h exp %h", r, 16'h1234); end
    peek(16'h0100, r);
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL ram_oob got %h exp %h", r, 16'h0000); end
    bus_write(16'h00FF, 16'hA5A5);
    bus_write(16'h0100, 16'h5555);
    bus_write(16'h1010, 16'h7777);
    peek(16'h00FF, r);
    vectors++; if (r !== 16'hA5A5) begin errors++; $display("FAIL ram_top got %h exp %h", r, 16'hA5A5); end
    peek(16'h0100, r);
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL ram_oob_wr got %h exp %h", r, 16'h0000); end
    peek(16'h0010, r);
    vectors++; if (r !== 16'h1234) begin errors++; $display("FAIL ram_alias got %h exp %h", r, 16'h1234); end
    peek(16'hFF04, r);
    vectors++; if (r !== 16'h0000) begin errors++; $display("FAIL unmapped got %h exp %h", r, 16'h0000); end
    @(negedge ck);
  endtask

  task automatic test_gpo;
    logic [15:0] r;
    bus_write(16'hFF00, 16'hC3C3);
    vectors++; if (gpo !== 16'hC3C3) begin errors++; $display("FAIL gpo_pin got %h exp %h", gpo, 16'hC3C3); end
    peek(16'hFF00, r);
    vectors++; if (r !== 16'hC3C3) begin errors++; $display("FAIL gpo_rd got %h exp %h", r, 16'hC3C3); end
    @(negedge ck);
  endtask

  task automatic test_coalesce;
    logic [15:0] r;
    txr = 1'b0;
    rw = 1'b0; da = 16'hFF01; dd_drv = 16'h00AA;
    repeat (5) @(negedge ck);
    peek(16'hFF01, r);
    vectors++; if (r !== 16'h0001) begin errors++; $display("FAIL coalesce_hold got %h exp %h", r, 16'h0001); end
    rw = 1'b0; da = 16'hFF01; dd_drv = 16'h00BB;
    @(negedge ck);
    rw = 1'b1;
    @(negedge ck);
    peek(16'hFF01, r);
    vectors++; if (r !== 16'h0002) begin errors++; $display("FAIL coalesce_change got %h exp %h", r, 16'h0002); end
    vectors++; if (txd !== 16'h00AA) begin errors++; $display("FAIL coalesce_head got %h exp %h", txd, 16'h00AA); end
    txr = 1'b1;
    repeat (2) @(negedge ck);
    txr = 1'b0;
    vectors++; if (txv !== 1'b0) begin errors++; $display("FAIL coalesce_drain got %b exp %b", txv, 1'b0); end
  endtask

  task automatic test_handshake;
    logic [15:0] r;
    txr = 1'b0;
    bus_write(16'hFF01, 16'h0001);
    bus_write(16'hFF01, 16'h0002);
    bus_write(16'hFF01, 16'h0003);
    txr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      vectors++; if (txd !== 16'(i) || txv !== 1'b1) begin errors++; $display("FAIL hs_seq%0d got %h/%b exp %h/1", i, txd, txv, 16'(i)); end
      @(negedge ck);
    end
    txr = 1'b0;
    vectors++; if (txv !== 1'b0 || txd !== 16'h0000) begin errors++; $display("FAIL hs_empty got %b/%h exp 0/0000", txv, txd); end
    peek(16'hFF02, r);
    vectors++; if (r !== 16'h0002) begin errors++; $display("FAIL hs_status got %h exp %h", r, 16'h0002); end
    @(negedge ck);
  endtask

  task automatic test_overflow_and_full_pushpop;
    logic [15:0] r;
    txr = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(16'hFF01, 16'h0100 + 16'(i));
    peek(16'hFF02, r);
    vectors++; if (r !== 16'h0005) begin errors++; $display("FAIL ovf_status got %h exp %h", r, 16'h0005); end
    peek(16'hFF01, r);
    vectors++; if (r !== 16'h0008) begin errors++; $display("FAIL ovf_count got %h exp %h", r, 16'h0008); end
    @(negedge ck);
    bus_write(16'hFF02, 16'h0000);
    peek(16'hFF02, r);
    vectors++; if (r !== 16'h0001) begin errors++; $display("FAIL ovf_clear got %h exp %h", r, 16'h0001); end
    @(negedge ck);
    // Full FIFO: push and pop on the same edge.
    rw = 1'b0; da = 16'hFF01; dd_drv = 16'h0777; txr = 1'b1;
    @(negedge ck);
    rw = 1'b1; txr = 1'b0;
    peek(16'hFF01, r);
    vectors++; if (r !== 16'h0008) begin errors++; $display("FAIL pp_count got %h exp %h", r, 16'h0008); end
    peek(16'hFF02, r);
    vectors++; if (r !== 16'h0001) begin errors++; $display("FAIL pp_status got %h exp %h", r, 16'h0001); end
    @(negedge ck);
    txr = 1'b1;
    for (int i = 1; i < 8; i++) begin
      vectors++; if (txd !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL drain%0d got %h exp %h", i, txd, 16'h0100 + 16'(i)); end
      @(negedge ck);
    end
    vectors++; if (txd !== 16'h0777) begin errors++; $display("FAIL drain_last got %h exp %h", txd, 16'h0777); end
    @(negedge ck);
    txr = 1'b0;
    vectors++; if (txv !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp %b", txv, 1'b0); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r;
    logic [15:0] exp_cnt;
    txr = 1'b0;
    bus_write(16'hFF00, 16'hBEEF);
    bus_write(16'hFF01, 16'h0011);
    bus_write(16'hFF01, 16'h0022);
    bus_write(16'hFF01, 16'h0033);
    bus_write(16'hFF03, 16'h0000);
    repeat (63) @(negedge ck);
`ifdef DBUS_IO_CYCLE_COUNTER_EN
    exp_cnt = 16'h0040;
`else
    exp_cnt = 16'h0000;
`endif
    peek(16'hFF03, r);
    vectors++; if (r !== exp_cnt) begin errors++; $display("FAIL rm_cnt_pre got %h exp %h", r, exp_cnt); end
    vectors++; if (gpo !== 16'hBEEF || txv !== 1'b1) begin errors++; $display("FAIL rm_pre got %h/%b exp beef/1", gpo, txv); end
    rst = 1'b1; txr = 1'b1;
    @(negedge ck);
    rst = 1'b0; txr = 1'b0;
    vectors++; if (gpo !== 16'h0000) begin errors++; $display("FAIL rm_gpo got %h exp %h", gpo, 16'h0000); end
    vectors++; if (txv !== 1'b0 || txd !== 16'h0000) begin errors++; $display("FAIL rm_fifo got %b/%h exp 0/0000", txv, txd); end
    @(negedge ck);
`ifdef DBUS_IO_CYCLE_COUNTER_EN
    exp_cnt = 16'h0001;
`else
    exp_cnt = 16'h0000;
`endif
    peek(16'hFF03, r);
    vectors++; if (r !== exp_cnt) begin errors++; $display("FAIL rm_cnt_post got %h exp %h", r, exp_cnt); end
    peek(16'h0010, r);
    vectors++; if (r !== 16'h1234) begin errors++; $display("FAIL rm_ram got %h exp %h", r, 16'h1234); end
    @(negedge ck);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpo();
    test_coalesce();
    test_handshake();
    test_overflow_and_full_pushpop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
